// File: rtl/mem_arb_pkg.sv
// Shared definitions for the shared-memory arbiter: arbitration modes and the
// response-routing tag carried alongside each issued memory access.
package mem_arb_pkg;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   localparam int MAX_PORTS = 8;
   localparam int PORT_ID_W = $clog2(MAX_PORTS);

   // port_id is sized for the largest supported port count; smaller
   // configurations leave the upper bits at zero.
   typedef struct packed {
      logic                 valid;
      logic [PORT_ID_W-1:0] port_id;
      logic                 is_write;
   } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Request arbiter: fixed priority (port 0 highest) or round-robin starting
// after the last accepted port. Grant is combinational; last_grant is registered.
module rr_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int MODE      = ARB_FIXED
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [NUM_PORTS-1:0] req,
   input  logic                 accept,
   output logic [NUM_PORTS-1:0] grant,
   output logic [PORT_ID_W-1:0] grant_id
);

   logic [PORT_ID_W-1:0] last_grant;

   // Scan ports in priority order beginning at start; the first requester wins.
   always_comb begin
      int   start;
      logic found;
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      start    = (MODE == ARB_RR) ? int'(last_grant) + 1 : 0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (!found && req[p] && (((start + k) % NUM_PORTS) == p)) begin
               found    = 1'b1;
               grant[p] = 1'b1;
               grant_id = PORT_ID_W'(p);
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         last_grant <= PORT_ID_W'(NUM_PORTS - 1);
      end else if (accept) begin
         last_grant <= grant_id;
      end
   end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Shares one fixed-latency single-ported memory among NUM_PORTS requesters:
// registered issue port, latency-matched tag pipeline, in-order response demux.
module shared_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MEM_LAT   = 1,
   parameter int ARB_MODE  = ARB_FIXED
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic [NUM_PORTS-1:0]        req_valid,
   output logic [NUM_PORTS-1:0]        req_ready,
   input  logic [NUM_PORTS-1:0]        req_we,
   input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
   input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
   output logic [NUM_PORTS-1:0]        rsp_valid,
   output logic [DATA_W-1:0]           rsp_rdata,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_wdata,
   output logic                        mem_re,
   output logic                        mem_we,
   input  logic [DATA_W-1:0]           mem_rdata
);

   logic [NUM_PORTS-1:0] grant;
   logic [PORT_ID_W-1:0] grant_id;
   logic                 accept;
   logic                 sel_we;
   logic [ADDR_W-1:0]    sel_addr;
   logic [DATA_W-1:0]    sel_wdata;
   tag_t                 tag_in;
   tag_t                 tag_q [MEM_LAT+1];

   rr_arbiter #(
      .NUM_PORTS (NUM_PORTS),
      .MODE      (ARB_MODE)
   ) u_arb (
      .clock    (clock),
      .reset_n  (reset_n),
      .req      (req_valid),
      .accept   (accept),
      .grant    (grant),
      .grant_id (grant_id)
   );

   assign req_ready = grant;
   assign accept    = |(req_valid & grant);

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (grant[p]) begin
            sel_we    = req_we[p];
            sel_addr  = req_addr[p*ADDR_W +: ADDR_W];
            sel_wdata = req_wdata[p*DATA_W +: DATA_W];
         end
      end
   end

   // Address and write data hold when idle so the memory bus stays quiet.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_re    <= 1'b0;
         mem_we    <= 1'b0;
      end else begin
         mem_re <= accept & ~sel_we;
         mem_we <= accept & sel_we;
         if (accept) begin
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
         end
      end
   end

   always_comb begin
      tag_in          = '0;
      tag_in.valid    = accept;
      tag_in.port_id  = grant_id;
      tag_in.is_write = sel_we;
   end

   // Stage k is visible k+1 cycles after acceptance; the last stage lines up
   // with mem_rdata for the matching read.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k <= MEM_LAT; k++) begin
            tag_q[k] <= '0;
         end
      end else begin
         tag_q[0] <= tag_in;
         for (int k = 1; k <= MEM_LAT; k++) begin
            tag_q[k] <= tag_q[k-1];
         end
      end
   end

   always_comb begin
      rsp_valid = '0;
      rsp_rdata = '0;
      if (tag_q[MEM_LAT].valid) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (tag_q[MEM_LAT].port_id == PORT_ID_W'(p)) begin
               rsp_valid[p] = 1'b1;
            end
         end
         if (!tag_q[MEM_LAT].is_write) begin
            rsp_rdata = mem_rdata;
         end
      end
   end

endmodule

// File: doc/shared_mem_arbiter.md
# shared_mem_arbiter

Parametrised arbiter that lets NUM_PORTS requesters (instruction fetch, data access, future DMA/debug) share one single-ported memory with fixed read latency. It is the successor to the ad-hoc fetch/data multiplexing inside the pipelined CPU. It sits between the CPU stages and `memoria_compartilhada`. Accepted requests are issued in order through a registered memory port, and each response is routed back to its originating port by a latency-matched tag pipeline.

## Interface
Parameters:
- NUM_PORTS, 2: number of requesters (2..8).
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- MEM_LAT, 1: cycles from `mem_re` high to valid `mem_rdata` (1..4).
- ARB_MODE, 0: 0 = fixed priority (port 0 highest), 1 = round-robin.

Ports (one clock; reset is asynchronous and active-low):
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_PORTS  request present, one bit per port.
- req_ready  out  NUM_PORTS  request accepted this cycle (one-hot or zero).
- req_we  in  NUM_PORTS  1 = write, 0 = read.
- req_addr  in  NUM_PORTS*ADDR_W  packed addresses; port p occupies bits [p*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_PORTS*DATA_W  packed write data.
- rsp_valid  out  NUM_PORTS  response strobe, one cycle.
- rsp_rdata  out  DATA_W  shared response data, qualified by rsp_valid.
- mem_addr  out  ADDR_W  registered memory address.
- mem_wdata  out  DATA_W  registered write data.
- mem_re  out  1  registered read strobe.
- mem_we  out  1  registered write strobe.
- mem_rdata  in  DATA_W  memory read data.

## Operation
- Each cycle the arbiter grants at most one port among those with req_valid = 1. Acceptance means req_valid[p] & req_ready[p].
- req_ready is combinational from req_valid and the arbiter state. A port with req_valid = 0 never sees req_ready = 1.
- Fixed mode: the lowest-index valid port wins.
- Round-robin mode: the search starts at last_grant+1 and wraps modulo NUM_PORTS. last_grant updates only on acceptance. Reset value of last_grant is NUM_PORTS-1, so port 0 wins first.
- An accepted request drives mem_addr/mem_wdata/mem_re/mem_we in the next cycle. With no acceptance, mem_re = mem_we = 0 and mem_addr/mem_wdata hold their previous values.
- Tag pipeline: MEM_LAT+1 stages of {valid, port_id, is_write}, advanced every cycle.
- A read tag emerging at the end of the pipeline asserts rsp_valid[port_id] and drives rsp_rdata = mem_rdata.
- A write tag asserts rsp_valid[port_id] as a completion ack with rsp_rdata = 0.
- With no tag emerging, rsp_rdata = 0.
- Requests are fully pipelined: one issue per cycle, no bubbles. Responses return in issue order.
- Responses have no backpressure; requesters must accept rsp_valid when it is asserted.
- A requester must hold req_* stable while req_valid is high and it has not yet been accepted.

## Timing
- Reset values: req_ready = 0 (combinational, follows grant), rsp_valid = 0, rsp_rdata = 0, mem_re = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, all tags invalid.
- Latency: acceptance at cycle t, mem strobe at t+1, rsp_valid at t+1+MEM_LAT.
- Throughput: one transaction per cycle sustained.
- Write followed by read to the same address (any ports) in consecutive accept cycles: the read returns the new data because issue order is preserved.
- Reset asserted mid-flight: all in-flight tags are discarded immediately and no rsp_valid appears after release. Memory strobes drop asynchronously.
- First acceptance after release is possible in the first cycle with reset_n = 1.
- Simultaneous requests from all ports in round-robin mode: each port is granted exactly once per NUM_PORTS consecutive accept cycles.

## Structure
- Package `mem_arb_pkg`: ARB_FIXED = 0, ARB_RR = 1, and a tag struct {valid, port_id[$clog2(NUM_PORTS)-1:0], is_write}.
- Sub-module `rr_arbiter` (NUM_PORTS, MODE): request vector in, one-hot grant out, last_grant register internal, advances on an `accept` input.
- Top level holds the issue registers, the tag shift pipeline and the response demux.

## Test plan
- Fixed mode, NUM_PORTS=2, both ports request reads continuously → port 0 is granted every cycle and port 1 req_ready stays 0; drop port 0 → port 1 is granted the next cycle.
- Round-robin, NUM_PORTS=4, all four request continuously → grant sequence 0,1,2,3,0,…; with ports 1 and 3 idle → sequence 0,2,0,2.
- MEM_LAT=2, port 1 issues back-to-back reads of 0x10, 0x14, 0x18 (memory preloaded 0xA,0xB,0xC) → rsp_valid[1] in cycles t+3, t+4, t+5 with data 0xA, 0xB, 0xC.
- Port 0 writes 0xDEADBEEF to 0x40, then port 1 reads 0x40 in the next cycle → port 0 write ack with rsp_rdata=0, then port 1 read returns 0xDEADBEEF.
- Assert reset_n low one cycle after accepting two reads → rsp_valid stays 0 through and after reset; outputs reach their reset values asynchronously.
- Idle cycle between requests → mem_re = mem_we = 0 that cycle and mem_addr holds its previous value.
